// File: rtl/radix_4_divider_pkg.sv
// Shared types and constants for the radix-4 restoring divider.
// Optional error flag is enabled with RADIX4_DIV_ERROR_EN.
package radix_4_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two quotient bits retire per iteration.
  function automatic int iter_count(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/radix_4_divider_if.sv
// Start/ready handshake and operand/result bus of the divider.
// The error signal exists only when RADIX4_DIV_ERROR_EN is defined.
interface radix_4_divider_if #(parameter int WIDTH = radix_4_pkg::DEFAULT_WIDTH);

  logic             start;
  logic [WIDTH-1:0] x_value;
  logic [WIDTH-1:0] y_value;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             ready;
`ifdef RADIX4_DIV_ERROR_EN
  logic             error;

  modport master (output start, x_value, y_value,
                  input  quotient, remainder, ready, error);
  modport slave  (input  start, x_value, y_value,
                  output quotient, remainder, ready, error);
`else
  modport master (output start, x_value, y_value,
                  input  quotient, remainder, ready);
  modport slave  (input  start, x_value, y_value,
                  output quotient, remainder, ready);
`endif

endinterface

// File: rtl/radix_4_divider_digit_select.sv
// Combinational radix-4 digit selection: largest q in {3,2,1,0} with q*|y| <= r.
module radix4_digit_select #(
  parameter int RW = 10
) (
  input  logic [RW-1:0] r_shift,
  input  logic [RW-1:0] y1,
  input  logic [RW-1:0] y2,
  input  logic [RW-1:0] y3,
  output logic [1:0]    digit,
  output logic [RW-1:0] r_next
);

  logic [RW-1:0] mult [4];
  logic [3:1]    fits;

  assign mult[0] = '0;
  assign mult[1] = y1;
  assign mult[2] = y2;
  assign mult[3] = y3;

  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_cmp
      assign fits[gi] = (mult[gi] <= r_shift);
    end
  endgenerate

  always_comb begin
    digit  = 2'd0;
    r_next = r_shift;
    if (fits[3]) begin
      digit  = 2'd3;
      r_next = r_shift - y3;
    end else if (fits[2]) begin
      digit  = 2'd2;
      r_next = r_shift - y2;
    end else if (fits[1]) begin
      digit  = 2'd1;
      r_next = r_shift - y1;
    end
  end

endmodule

// File: rtl/radix_4_divider.sv
// Sequential signed divider, two quotient bits per cycle (restoring radix-4).
// Defining RADIX4_DIV_ERROR_EN adds an error flag for divide-by-zero and overflow.
module radix_4_divider
  import radix_4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  radix_4_divider_if.slave bus
);

  localparam int ITERS = iter_count(WIDTH);
  localparam int RW    = WIDTH + 2;
  localparam int IW    = $clog2(ITERS + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_reg, state_next;
  logic   load_en, iter_en, fix_en, last_iter;

  logic [WIDTH-1:0] x_mag_reg, y_mag_reg, q_mag_reg, x_raw_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic [RW-1:0]    r_reg;
  logic [IW-1:0]    iter_reg;
  logic             neg_q_reg, neg_r_reg, div_zero_reg, ovf_reg, ready_reg;

  logic [WIDTH-1:0] x_abs, y_abs, q_res, r_low, r_res;
  logic [RW-1:0]    y1, y2, y3, r_shift, r_next;
  logic [1:0]       digit;

  assign last_iter = (iter_reg == IW'(ITERS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (bus.start) state_next = ITER;
      ITER:       if (last_iter) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    iter_en = 1'b0;
    fix_en  = 1'b0;
    case (state_reg)
      IDLE, DONE: load_en = bus.start;
      ITER:       iter_en = 1'b1;
      FIX:        fix_en  = 1'b1;
      default:    ;
    endcase
  end

  // Magnitudes are unsigned so |most-negative| needs no extra bit.
  assign x_abs = bus.x_value[WIDTH-1] ? (~bus.x_value + 1'b1) : bus.x_value;
  assign y_abs = bus.y_value[WIDTH-1] ? (~bus.y_value + 1'b1) : bus.y_value;

  assign y1      = RW'(y_mag_reg);
  assign y2      = y1 << 1;
  assign y3      = y1 + y2;
  assign r_shift = {r_reg[RW-3:0], x_mag_reg[WIDTH-1 -: 2]};

  radix4_digit_select #(.RW(RW)) u_digit (
    .r_shift (r_shift),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .digit   (digit),
    .r_next  (r_next)
  );

  assign r_low = r_reg[WIDTH-1:0];
  assign q_res = neg_q_reg ? (~q_mag_reg + 1'b1) : q_mag_reg;
  assign r_res = neg_r_reg ? (~r_low + 1'b1) : r_low;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_mag_reg     <= '0;
      y_mag_reg     <= '0;
      q_mag_reg     <= '0;
      x_raw_reg     <= '0;
      r_reg         <= '0;
      iter_reg      <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      div_zero_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
      ready_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if (load_en) begin
      x_mag_reg    <= x_abs;
      y_mag_reg    <= y_abs;
      q_mag_reg    <= '0;
      x_raw_reg    <= bus.x_value;
      r_reg        <= '0;
      iter_reg     <= '0;
      neg_q_reg    <= bus.x_value[WIDTH-1] ^ bus.y_value[WIDTH-1];
      neg_r_reg    <= bus.x_value[WIDTH-1];
      div_zero_reg <= (bus.y_value == '0);
      ovf_reg      <= (bus.x_value == MOST_NEG) && (&bus.y_value);
      ready_reg    <= 1'b0;
    end else if (iter_en) begin
      x_mag_reg <= x_mag_reg << 2;
      r_reg     <= r_next;
      q_mag_reg <= {q_mag_reg[WIDTH-3:0], digit};
      iter_reg  <= iter_reg + IW'(1);
    end else if (fix_en) begin
      quotient_reg  <= div_zero_reg ? '1 : q_res;
      remainder_reg <= div_zero_reg ? x_raw_reg : r_res;
      ready_reg     <= 1'b1;
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.ready     = ready_reg;

`ifdef RADIX4_DIV_ERROR_EN
  logic error_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       error_reg <= 1'b0;
    else if (load_en) error_reg <= 1'b0;
    else if (fix_en)  error_reg <= div_zero_reg | ovf_reg;
  end

  assign bus.error = error_reg;
`endif

endmodule

// File: tb/tb_radix_4_divider.sv
// Directed vector bench for radix_4_divider (WIDTH=8), one line per transaction.
module tb_radix_4_divider;
  import radix_4_pkg::*;

  localparam int W   = 8;
  localparam int LAT = W / 2 + 1;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  radix_4_divider_if #(.WIDTH(W)) bus ();

  radix_4_divider #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int q;
    int r;
    bit err;
  } vec_t;

  vec_t vecs [15];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sq();
    return int'($signed(bus.quotient));
  endfunction

  function automatic int sr();
    return int'($signed(bus.remainder));
  endfunction

  task automatic launch(input int x, input int y, input bit hold);
    @(posedge clock);
    #1;
    bus.start   = 1'b1;
    bus.x_value = W'(x);
    bus.y_value = W'(y);
    @(posedge clock);
    #1;
    if (!hold) bus.start = 1'b0;
    check("ready_drop", int'(bus.ready), 0);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!bus.ready && cycles < 40) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic check_result(input string tag, input int q, input int r, input bit err);
    check({tag, "_q"}, sq(), q);
    check({tag, "_r"}, sr(), r);
`ifdef RADIX4_DIV_ERROR_EN
    check({tag, "_err"}, int'(bus.error), int'(err));
`endif
    $display("%s: q=%0d r=%0d (want %0d, %0d)", tag, sq(), sr(), q, r);
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{x:  100, y:    7, q:   14, r:    2, err: 1'b0};
    vecs[1]  = '{x: -100, y:    7, q:  -14, r:   -2, err: 1'b0};
    vecs[2]  = '{x:  100, y:   -7, q:  -14, r:    2, err: 1'b0};
    vecs[3]  = '{x: -100, y:   -7, q:   14, r:   -2, err: 1'b0};
    vecs[4]  = '{x: -128, y:   -1, q: -128, r:    0, err: 1'b1};
    vecs[5]  = '{x:    5, y:    0, q:   -1, r:    5, err: 1'b1};
    vecs[6]  = '{x: -128, y:    0, q:   -1, r: -128, err: 1'b1};
    vecs[7]  = '{x:  127, y:    3, q:   42, r:    1, err: 1'b0};
    vecs[8]  = '{x:    3, y:  127, q:    0, r:    3, err: 1'b0};
    vecs[9]  = '{x: -128, y:    1, q: -128, r:    0, err: 1'b0};
    vecs[10] = '{x:  127, y: -128, q:    0, r:  127, err: 1'b0};
    vecs[11] = '{x: -128, y: -128, q:    1, r:    0, err: 1'b0};
    vecs[12] = '{x:   -1, y:    2, q:    0, r:   -1, err: 1'b0};
    vecs[13] = '{x:    7, y:    7, q:    1, r:    0, err: 1'b0};
    vecs[14] = '{x: -128, y:    3, q:  -42, r:   -2, err: 1'b0};

    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.x_value = '0;
    bus.y_value = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_q", int'(bus.quotient), 0);
    check("rst_r", int'(bus.remainder), 0);
    check("rst_ready", int'(bus.ready), 0);
`ifdef RADIX4_DIV_ERROR_EN
    check("rst_err", int'(bus.error), 0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].x, vecs[i].y, 1'b0);
      wait_ready(cyc);
      check($sformatf("vec%0d_lat", i), cyc, LAT);
      check_result($sformatf("vec%0d %0d/%0d", i, vecs[i].x, vecs[i].y),
                   vecs[i].q, vecs[i].r, vecs[i].err);
    end

    // start re-pulsed with other operands while busy must be ignored
    launch(100, 7, 1'b0);
    @(posedge clock);
    #1;
    bus.start   = 1'b1;
    bus.x_value = W'(5);
    bus.y_value = W'(1);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_ready(cyc);
    check("repulse_lat", cyc + 2, LAT);
    check_result("repulse 100/7", 14, 2, 1'b0);

    // asynchronous reset in the middle of an operation
    launch(-100, 7, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_q", int'(bus.quotient), 0);
    check("midrst_r", int'(bus.remainder), 0);
    check("midrst_ready", int'(bus.ready), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("idle_after_reset", int'(bus.ready), 0);
    $display("reset mid-ITER: q=%0d r=%0d ready=%0d", sq(), sr(), bus.ready);
    launch(-100, 7, 1'b0);
    wait_ready(cyc);
    check("post_reset_lat", cyc, LAT);
    check_result("post-reset -100/7", -14, -2, 1'b0);

    // start held high: second operands captured on the DONE relaunch
    launch(127, 3, 1'b1);
    bus.x_value = W'(3);
    bus.y_value = W'(127);
    wait_ready(cyc);
    check("b2b1_lat", cyc, LAT);
    check_result("b2b 127/3", 42, 1, 1'b0);
    @(posedge clock);
    #1;
    check("relaunch_drop", int'(bus.ready), 0);
    bus.start = 1'b0;
    wait_ready(cyc);
    check("b2b2_lat", cyc, LAT);
    check_result("b2b 3/127", 0, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/radix_4_divider.md
# radix_4_divider

Sequential signed integer divider that retires two quotient bits per cycle using a restoring radix-4 recurrence. It is the inverse companion of the team's radix-4 Booth multiplier and uses the same start/ready handshake and operand port names, so a datapath controller can issue multiply or divide the same way. It accepts a WIDTH-bit signed dividend and divisor and produces a truncating quotient and a remainder.

## Interface
- WIDTH, 8, operand/result width in bits; must be even and ≥ 4. The iteration count is WIDTH/2.
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state whenever low.
- start  input  1  request pulse or level; sampled only in IDLE or DONE.
- x_value  input  WIDTH  signed dividend; captured on the accepting edge.
- y_value  input  WIDTH  signed divisor; captured on the accepting edge.
- quotient  output  WIDTH  signed quotient, truncated toward zero. Reset value 0.
- remainder  output  WIDTH  signed remainder; carries the sign of the dividend. Reset value 0.
- ready  output  1  result valid. Reset value 0.
- error  output  1  present only with RADIX4_DIV_ERROR_EN. Reset value 0.

## Operation
- **States:** IDLE, ITER, FIX, DONE.
- **IDLE:** if start=1, capture the operands, clear ready (and error), record the result signs, load the magnitudes |x| and |y|, zero the partial remainder r (WIDTH+2 bits), set iter=0, go to ITER.
- **ITER, each cycle:**
  - r ← (r<<2) | next two MSBs of |x|.
  - Select digit q ∈ {3,2,1,0}: the largest q with q·|y| ≤ r.
  - r ← r − q·|y|.
  - Shift q into the quotient magnitude.
  - iter+1. After WIDTH/2 iterations, go to FIX.
- **FIX:**
  - Quotient = magnitude, negated if the operand signs differ.
  - Remainder = r, negated if x is negative.
  - Write the outputs, set ready=1, go to DONE.
- **Divide by zero** (y=0): FIX forces quotient = all ones (−1) and remainder = x_value. Latency is unchanged.
- **Overflow** (x = most-negative, y = −1): the quotient wraps to the most-negative value and the remainder is 0. No special path is needed.
- **DONE:**
  - Outputs and ready hold while start=0.
  - start=1 behaves exactly as in IDLE: new capture, ready drops on that edge.
- **Busy:** start is ignored in ITER and FIX. Input changes after the capture edge have no effect.
- **Reset mid-operation:** all registers clear immediately and the state returns to IDLE. There is no partial output.
- **Arithmetic:** magnitudes are held unsigned, so |most-negative| is representable. Multiples 2|y| and 3|y| are formed at WIDTH+2 bits.

## Timing
- start seen high at edge N → ITER during N+1…N+WIDTH/2 → FIX → ready=1 after edge N + WIDTH/2 + 1 (edge N+5 for WIDTH=8).
- Back-to-back: start held high in DONE re-launches one cycle after ready rises, giving a throughput of one result per WIDTH/2+2 cycles.
- quotient and remainder change only at the FIX edge or on reset.

## Configuration
- **RADIX4_DIV_ERROR_EN defined:**
  - The error port exists.
  - error is set at the FIX edge, together with ready, for divide-by-zero or overflow.
  - error clears on the next accepted start or on reset.
- **Not defined:** no error port. Results follow the rules above silently.

## Structure
- **Package radix_4_pkg:** the state enum (IDLE/ITER/FIX/DONE), the default WIDTH constant, and a helper that computes the iteration count.
- **Sub-module radix4_digit_select:** combinational block.
  - Inputs: shifted r, |y|, 2|y|, 3|y|.
  - Outputs: the 2-bit digit and the next remainder.
  - It is shared with any future SRT variant.

## Test plan
- 100 / 7 → quotient 14, remainder 2, ready after exactly 5 cycles, error 0.
- −100 / 7 → −14, −2; 100 / −7 → −14, 2; −100 / −7 → 14, −2.
- −128 / −1 → quotient −128, remainder 0; error=1 with the macro.
- 5 / 0 → quotient −1 (8'hFF), remainder 5; error=1 with the macro. −128 / 0 → −1, −128.
- start re-pulsed mid-ITER is ignored and the result matches the first operands. reset low during ITER → all outputs 0 and state IDLE at once; a fresh start then completes normally.
- start held high through DONE: 127/3 then 3/127 back-to-back → (42, 1) then (0, 3). ready drops for the relaunch.
